// File: rtl/alu_rsv_station_pkg.sv
// Shared definitions for the ALU reservation station and the ALU itself:
// operation codes and the default ROB tag width.
package alu_rsv_station_pkg;

   localparam int RS_TAG_W = 4;

   localparam logic [5:0] AluOp_Add = 6'd0;
   localparam logic [5:0] AluOp_Sub = 6'd1;
   localparam logic [5:0] AluOp_And = 6'd2;
   localparam logic [5:0] AluOp_Or  = 6'd3;
   localparam logic [5:0] AluOp_Xor = 6'd4;
   localparam logic [5:0] AluOp_Nor = 6'd5;
   localparam logic [5:0] AluOp_Slt = 6'd6;
   localparam logic [5:0] AluOp_Sll = 6'd7;
   localparam logic [5:0] AluOp_Srl = 6'd8;
   localparam logic [5:0] AluOp_Sra = 6'd9;
   localparam logic [5:0] AluOp_Lui = 6'd10;

endpackage

// File: rtl/alu_rs_entry.sv
// One reservation-station slot: registered fields plus the CDB wakeup view
// that the top level feeds back (or shifts down) as next-cycle contents.
module alu_rs_entry
   import alu_rsv_station_pkg::*;
#(
   parameter int TAG_W = RS_TAG_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             cdb_valid_i,
   input  logic [TAG_W-1:0] cdb_tag_i,
   input  logic [31:0]      cdb_data_i,
   input  logic             ld_valid_i,
   input  logic [5:0]       ld_op_i,
   input  logic [TAG_W-1:0] ld_rob_tag_i,
   input  logic             ld_s1_rdy_i,
   input  logic [31:0]      ld_s1_val_i,
   input  logic [TAG_W-1:0] ld_s1_tag_i,
   input  logic             ld_s2_rdy_i,
   input  logic [31:0]      ld_s2_val_i,
   input  logic [TAG_W-1:0] ld_s2_tag_i,
   input  logic [31:0]      ld_imm_i,
   output logic             valid_o,
   output logic [5:0]       op_o,
   output logic [TAG_W-1:0] rob_tag_o,
   output logic             s1_rdy_o,
   output logic [31:0]      s1_val_o,
   output logic [TAG_W-1:0] s1_tag_o,
   output logic             s2_rdy_o,
   output logic [31:0]      s2_val_o,
   output logic [TAG_W-1:0] s2_tag_o,
   output logic [31:0]      imm_o,
   output logic             wk_s1_rdy_o,
   output logic [31:0]      wk_s1_val_o,
   output logic             wk_s2_rdy_o,
   output logic [31:0]      wk_s2_val_o
);

   logic             valid_q;
   logic [5:0]       op_q;
   logic [TAG_W-1:0] rob_tag_q;
   logic             s1_rdy_q;
   logic [31:0]      s1_val_q;
   logic [TAG_W-1:0] s1_tag_q;
   logic             s2_rdy_q;
   logic [31:0]      s2_val_q;
   logic [TAG_W-1:0] s2_tag_q;
   logic [31:0]      imm_q;
   logic             s1_hit;
   logic             s2_hit;

   // The slot reloads every cycle; the top decides whether that is itself,
   // its upper neighbour, or a new dispatch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q   <= 1'b0;
         op_q      <= '0;
         rob_tag_q <= '0;
         s1_rdy_q  <= 1'b0;
         s1_val_q  <= '0;
         s1_tag_q  <= '0;
         s2_rdy_q  <= 1'b0;
         s2_val_q  <= '0;
         s2_tag_q  <= '0;
         imm_q     <= '0;
      end else begin
         valid_q   <= ld_valid_i & ~flush_i;
         op_q      <= ld_op_i;
         rob_tag_q <= ld_rob_tag_i;
         s1_rdy_q  <= ld_s1_rdy_i;
         s1_val_q  <= ld_s1_val_i;
         s1_tag_q  <= ld_s1_tag_i;
         s2_rdy_q  <= ld_s2_rdy_i;
         s2_val_q  <= ld_s2_val_i;
         s2_tag_q  <= ld_s2_tag_i;
         imm_q     <= ld_imm_i;
      end
   end

   assign s1_hit = cdb_valid_i && !s1_rdy_q && (cdb_tag_i == s1_tag_q);
   assign s2_hit = cdb_valid_i && !s2_rdy_q && (cdb_tag_i == s2_tag_q);

   assign wk_s1_rdy_o = s1_rdy_q | s1_hit;
   assign wk_s1_val_o = s1_hit ? cdb_data_i : s1_val_q;
   assign wk_s2_rdy_o = s2_rdy_q | s2_hit;
   assign wk_s2_val_o = s2_hit ? cdb_data_i : s2_val_q;

   assign valid_o   = valid_q;
   assign op_o      = op_q;
   assign rob_tag_o = rob_tag_q;
   assign s1_rdy_o  = s1_rdy_q;
   assign s1_val_o  = s1_val_q;
   assign s1_tag_o  = s1_tag_q;
   assign s2_rdy_o  = s2_rdy_q;
   assign s2_val_o  = s2_val_q;
   assign s2_tag_o  = s2_tag_q;
   assign imm_o     = imm_q;

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: compacting age-ordered queue with CDB wakeup and
// oldest-ready select; valid/ready handshakes on dispatch and issue ports.
module alu_rsv_station
   import alu_rsv_station_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = RS_TAG_W,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [5:0]       disp_op,
   input  logic [TAG_W-1:0] disp_rob_tag,
   input  logic             disp_s1_rdy,
   input  logic [31:0]      disp_s1_val,
   input  logic [TAG_W-1:0] disp_s1_tag,
   input  logic             disp_s2_rdy,
   input  logic [31:0]      disp_s2_val,
   input  logic [TAG_W-1:0] disp_s2_tag,
   input  logic [31:0]      disp_imm,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   output logic             iss_valid,
   input  logic             iss_ready,
   output logic [31:0]      iss_src1,
   output logic [31:0]      iss_src2,
   output logic [31:0]      iss_imm,
   output logic [5:0]       iss_op,
   output logic [TAG_W-1:0] iss_rob_tag,
   output logic [CNT_W-1:0] occupancy
);

   // Index DEPTH is a permanently empty phantom slot that shifts into the top.
   logic [DEPTH:0]   x_valid;
   logic [5:0]       x_op     [DEPTH+1];
   logic [TAG_W-1:0] x_rob    [DEPTH+1];
   logic [TAG_W-1:0] x_s1_tag [DEPTH+1];
   logic [TAG_W-1:0] x_s2_tag [DEPTH+1];
   logic [31:0]      x_imm    [DEPTH+1];
   logic [DEPTH:0]   wk_s1_rdy;
   logic [DEPTH:0]   wk_s2_rdy;
   logic [31:0]      wk_s1_val [DEPTH+1];
   logic [31:0]      wk_s2_val [DEPTH+1];

   logic [DEPTH-1:0] r_s1_rdy;
   logic [DEPTH-1:0] r_s2_rdy;
   logic [31:0]      r_s1_val [DEPTH];
   logic [31:0]      r_s2_val [DEPTH];

   logic [DEPTH-1:0] n_valid;
   logic [5:0]       n_op     [DEPTH];
   logic [TAG_W-1:0] n_rob    [DEPTH];
   logic [DEPTH-1:0] n_s1_rdy;
   logic [31:0]      n_s1_val [DEPTH];
   logic [TAG_W-1:0] n_s1_tag [DEPTH];
   logic [DEPTH-1:0] n_s2_rdy;
   logic [31:0]      n_s2_val [DEPTH];
   logic [TAG_W-1:0] n_s2_tag [DEPTH];
   logic [31:0]      n_imm    [DEPTH];

   logic [CNT_W-1:0] occ_q;
   logic [CNT_W-1:0] occ_d;
   logic             disp_fire;
   logic             iss_fire;
   int               sel_idx;
   int               wr_idx;
   logic             d_s1_hit;
   logic             d_s2_hit;
   logic             d_s1_rdy;
   logic             d_s2_rdy;
   logic [31:0]      d_s1_val;
   logic [31:0]      d_s2_val;

   assign x_valid[DEPTH]   = 1'b0;
   assign x_op[DEPTH]      = '0;
   assign x_rob[DEPTH]     = '0;
   assign x_s1_tag[DEPTH]  = '0;
   assign x_s2_tag[DEPTH]  = '0;
   assign x_imm[DEPTH]     = '0;
   assign wk_s1_rdy[DEPTH] = 1'b0;
   assign wk_s2_rdy[DEPTH] = 1'b0;
   assign wk_s1_val[DEPTH] = '0;
   assign wk_s2_val[DEPTH] = '0;

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      alu_rs_entry #(.TAG_W(TAG_W)) u_entry (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .flush_i      (flush),
         .cdb_valid_i  (cdb_valid),
         .cdb_tag_i    (cdb_tag),
         .cdb_data_i   (cdb_data),
         .ld_valid_i   (n_valid[g]),
         .ld_op_i      (n_op[g]),
         .ld_rob_tag_i (n_rob[g]),
         .ld_s1_rdy_i  (n_s1_rdy[g]),
         .ld_s1_val_i  (n_s1_val[g]),
         .ld_s1_tag_i  (n_s1_tag[g]),
         .ld_s2_rdy_i  (n_s2_rdy[g]),
         .ld_s2_val_i  (n_s2_val[g]),
         .ld_s2_tag_i  (n_s2_tag[g]),
         .ld_imm_i     (n_imm[g]),
         .valid_o      (x_valid[g]),
         .op_o         (x_op[g]),
         .rob_tag_o    (x_rob[g]),
         .s1_rdy_o     (r_s1_rdy[g]),
         .s1_val_o     (r_s1_val[g]),
         .s1_tag_o     (x_s1_tag[g]),
         .s2_rdy_o     (r_s2_rdy[g]),
         .s2_val_o     (r_s2_val[g]),
         .s2_tag_o     (x_s2_tag[g]),
         .imm_o        (x_imm[g]),
         .wk_s1_rdy_o  (wk_s1_rdy[g]),
         .wk_s1_val_o  (wk_s1_val[g]),
         .wk_s2_rdy_o  (wk_s2_rdy[g]),
         .wk_s2_val_o  (wk_s2_val[g])
      );
   end

   // Oldest-ready select works on registered readiness only, so a CDB capture
   // becomes issuable one cycle later.
   always_comb begin
      iss_valid   = 1'b0;
      sel_idx     = 0;
      iss_src1    = '0;
      iss_src2    = '0;
      iss_imm     = '0;
      iss_op      = '0;
      iss_rob_tag = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (x_valid[i] && r_s1_rdy[i] && r_s2_rdy[i]) begin
            iss_valid   = 1'b1;
            sel_idx     = i;
            iss_src1    = r_s1_val[i];
            iss_src2    = r_s2_val[i];
            iss_imm     = x_imm[i];
            iss_op      = x_op[i];
            iss_rob_tag = x_rob[i];
         end
      end
   end

   assign disp_ready = (occ_q < CNT_W'(DEPTH));
   assign disp_fire  = disp_valid && disp_ready;
   assign iss_fire   = iss_valid && iss_ready;
   assign wr_idx     = int'(occ_q) - (iss_fire ? 1 : 0);

   assign d_s1_hit = !disp_s1_rdy && cdb_valid && (cdb_tag == disp_s1_tag);
   assign d_s2_hit = !disp_s2_rdy && cdb_valid && (cdb_tag == disp_s2_tag);
   assign d_s1_rdy = disp_s1_rdy | d_s1_hit;
   assign d_s2_rdy = disp_s2_rdy | d_s2_hit;
   assign d_s1_val = d_s1_hit ? cdb_data : disp_s1_val;
   assign d_s2_val = d_s2_hit ? cdb_data : disp_s2_val;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         n_valid[i]  = x_valid[i];
         n_op[i]     = x_op[i];
         n_rob[i]    = x_rob[i];
         n_s1_rdy[i] = wk_s1_rdy[i];
         n_s1_val[i] = wk_s1_val[i];
         n_s1_tag[i] = x_s1_tag[i];
         n_s2_rdy[i] = wk_s2_rdy[i];
         n_s2_val[i] = wk_s2_val[i];
         n_s2_tag[i] = x_s2_tag[i];
         n_imm[i]    = x_imm[i];
         if (iss_fire && i >= sel_idx) begin
            n_valid[i]  = x_valid[i+1];
            n_op[i]     = x_op[i+1];
            n_rob[i]    = x_rob[i+1];
            n_s1_rdy[i] = wk_s1_rdy[i+1];
            n_s1_val[i] = wk_s1_val[i+1];
            n_s1_tag[i] = x_s1_tag[i+1];
            n_s2_rdy[i] = wk_s2_rdy[i+1];
            n_s2_val[i] = wk_s2_val[i+1];
            n_s2_tag[i] = x_s2_tag[i+1];
            n_imm[i]    = x_imm[i+1];
         end
         if (disp_fire && i == wr_idx) begin
            n_valid[i]  = 1'b1;
            n_op[i]     = disp_op;
            n_rob[i]    = disp_rob_tag;
            n_s1_rdy[i] = d_s1_rdy;
            n_s1_val[i] = d_s1_val;
            n_s1_tag[i] = disp_s1_tag;
            n_s2_rdy[i] = d_s2_rdy;
            n_s2_val[i] = d_s2_val;
            n_s2_tag[i] = disp_s2_tag;
            n_imm[i]    = disp_imm;
         end
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (disp_fire && !iss_fire) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (iss_fire && !disp_fire) begin
         occ_d = occ_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed bench for alu_rsv_station: stimulus pushes expected issue tuples,
// an independent monitor pops and compares on every issue handshake.
module tb_alu_rsv_station;
   import alu_rsv_station_pkg::*;

   localparam int TAG_W = 4;
   localparam int CNT_W = 3;
   localparam int W     = 6 + TAG_W + 96;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             disp_valid;
   logic             disp_ready;
   logic [5:0]       disp_op;
   logic [TAG_W-1:0] disp_rob_tag;
   logic             disp_s1_rdy;
   logic [31:0]      disp_s1_val;
   logic [TAG_W-1:0] disp_s1_tag;
   logic             disp_s2_rdy;
   logic [31:0]      disp_s2_val;
   logic [TAG_W-1:0] disp_s2_tag;
   logic [31:0]      disp_imm;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;
   logic             iss_valid;
   logic             iss_ready;
   logic [31:0]      iss_src1;
   logic [31:0]      iss_src2;
   logic [31:0]      iss_imm;
   logic [5:0]       iss_op;
   logic [TAG_W-1:0] iss_rob_tag;
   logic [CNT_W-1:0] occupancy;

   logic [W-1:0] exp_q[$];
   int n_total;
   int n_bad;

   alu_rsv_station #(.DEPTH(4), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .disp_valid   (disp_valid),
      .disp_ready   (disp_ready),
      .disp_op      (disp_op),
      .disp_rob_tag (disp_rob_tag),
      .disp_s1_rdy  (disp_s1_rdy),
      .disp_s1_val  (disp_s1_val),
      .disp_s1_tag  (disp_s1_tag),
      .disp_s2_rdy  (disp_s2_rdy),
      .disp_s2_val  (disp_s2_val),
      .disp_s2_tag  (disp_s2_tag),
      .disp_imm     (disp_imm),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .iss_valid    (iss_valid),
      .iss_ready    (iss_ready),
      .iss_src1     (iss_src1),
      .iss_src2     (iss_src2),
      .iss_imm      (iss_imm),
      .iss_op       (iss_op),
      .iss_rob_tag  (iss_rob_tag),
      .occupancy    (occupancy)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_disp(input logic [5:0] op, input logic [TAG_W-1:0] rob,
                           input logic s1r, input logic [31:0] s1v, input logic [TAG_W-1:0] s1t,
                           input logic s2r, input logic [31:0] s2v, input logic [TAG_W-1:0] s2t,
                           input logic [31:0] imm);
      disp_valid   = 1'b1;
      disp_op      = op;
      disp_rob_tag = rob;
      disp_s1_rdy  = s1r;
      disp_s1_val  = s1v;
      disp_s1_tag  = s1t;
      disp_s2_rdy  = s2r;
      disp_s2_val  = s2v;
      disp_s2_tag  = s2t;
      disp_imm     = imm;
   endtask

   task automatic clr_disp();
      disp_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [5:0] op, input logic [TAG_W-1:0] rob,
                           input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm);
      exp_q.push_back({op, rob, s1, s2, imm});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   logic [W-1:0] exp_item;
   always @(negedge clk) begin
      if (rst_n && !flush && iss_valid && iss_ready) begin
         n_total++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_issue: got rob=%0h op=%0h with empty expected queue",
                     iss_rob_tag, iss_op);
         end else begin
            exp_item = exp_q.pop_front();
            if ({iss_op, iss_rob_tag, iss_src1, iss_src2, iss_imm} !== exp_item) begin
               n_bad++;
               $display("FAIL issue: got op=%0h rob=%0h s1=%0h s2=%0h imm=%0h expected op=%0h rob=%0h s1=%0h s2=%0h imm=%0h",
                        iss_op, iss_rob_tag, iss_src1, iss_src2, iss_imm,
                        exp_item[W-1 -: 6], exp_item[W-7 -: TAG_W], exp_item[95:64],
                        exp_item[63:32], exp_item[31:0]);
            end
         end
      end
   end

   logic [5:0] op_tab [5];

   initial begin
      n_total = 0;
      n_bad   = 0;
      op_tab[0] = AluOp_Add;
      op_tab[1] = AluOp_And;
      op_tab[2] = AluOp_Xor;
      op_tab[3] = AluOp_Or;
      op_tab[4] = AluOp_Sub;
      rst_n = 1'b0;
      flush = 1'b0;
      iss_ready = 1'b0;
      cdb_valid = 1'b0;
      cdb_tag = '0;
      cdb_data = '0;
      set_disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
      clr_disp();
      repeat (3) tick();
      rst_n = 1'b1;

      // Reset state
      sample();
      chk("reset_occ", 32'(occupancy), 0);
      chk("reset_disp_ready", 32'(disp_ready), 1);
      chk("reset_iss_valid", 32'(iss_valid), 0);
      chk("reset_iss_src1", iss_src1, 0);
      tick();

      // Simple Add, both operands ready
      iss_ready = 1'b1;
      set_disp(AluOp_Add, 4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0);
      push_exp(AluOp_Add, 4'd1, 32'd5, 32'd7, 32'd0);
      sample();
      chk("add_occ_before", 32'(occupancy), 0);
      tick();
      clr_disp();
      sample();
      chk("add_occ_after_disp", 32'(occupancy), 1);
      chk("add_iss_valid", 32'(iss_valid), 1);
      tick();
      sample();
      chk("add_occ_after_issue", 32'(occupancy), 0);
      chk("add_iss_valid_gone", 32'(iss_valid), 0);
      tick();

      // Sub waits on tag 3, younger Or overtakes it
      set_disp(AluOp_Sub, 4'd2, 1'b0, 32'd0, 4'd3, 1'b1, 32'd4, 4'd0, 32'd0);
      tick();
      set_disp(AluOp_Or, 4'd3, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0);
      tick();
      clr_disp();
      push_exp(AluOp_Or, 4'd3, 32'd1, 32'd2, 32'd0);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd3;
      cdb_data  = 32'h10;
      sample();
      chk("ooo_occ", 32'(occupancy), 2);
      chk("ooo_first_rob", 32'(iss_rob_tag), 3);
      tick();
      cdb_valid = 1'b0;
      push_exp(AluOp_Sub, 4'd2, 32'h10, 32'd4, 32'd0);
      sample();
      chk("ooo_sub_valid", 32'(iss_valid), 1);
      chk("ooo_occ_1", 32'(occupancy), 1);
      tick();
      sample();
      chk("ooo_occ_0", 32'(occupancy), 0);
      tick();

      // Both sources wake on one broadcast; not issuable in the capture cycle
      set_disp(AluOp_Xor, 4'd4, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd6, 32'd3);
      tick();
      clr_disp();
      cdb_valid = 1'b1;
      cdb_tag   = 4'd6;
      cdb_data  = 32'h55;
      sample();
      chk("wake_same_cycle_valid", 32'(iss_valid), 0);
      tick();
      cdb_valid = 1'b0;
      push_exp(AluOp_Xor, 4'd4, 32'h55, 32'h55, 32'd3);
      sample();
      chk("wake_next_cycle_valid", 32'(iss_valid), 1);
      tick();
      sample();
      chk("wake_occ_0", 32'(occupancy), 0);
      tick();

      // Fill to capacity, hold a fifth dispatch
      iss_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         push_exp(op_tab[k], 4'(4 + k), 32'h100 + k, 32'h200 + k, 32'(k));
      for (int k = 0; k < 4; k++) begin
         set_disp(op_tab[k], 4'(4 + k), 1'b1, 32'h100 + k, 4'd0, 1'b1, 32'h200 + k, 4'd0, 32'(k));
         tick();
      end
      set_disp(op_tab[4], 4'd8, 1'b1, 32'h104, 4'd0, 1'b1, 32'h204, 4'd0, 32'd4);
      sample();
      chk("full_disp_ready", 32'(disp_ready), 0);
      chk("full_occ", 32'(occupancy), 4);
      tick();
      iss_ready = 1'b1;
      sample();
      chk("full_held_occ", 32'(occupancy), 4);
      chk("full_held_ready", 32'(disp_ready), 0);
      tick();
      sample();
      chk("full_after_issue_occ", 32'(occupancy), 3);
      chk("full_ready_back", 32'(disp_ready), 1);
      tick();
      clr_disp();
      sample();
      chk("full_swap_occ", 32'(occupancy), 3);
      repeat (3) tick();
      sample();
      chk("full_drained_occ", 32'(occupancy), 0);
      tick();

      // Dispatch bypass from the CDB
      set_disp(AluOp_Add, 4'd9, 1'b1, 32'd1, 4'd0, 1'b0, 32'($urandom_range(0, 255)), 4'd5, 32'h20);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd5;
      cdb_data  = 32'hABCD;
      push_exp(AluOp_Add, 4'd9, 32'd1, 32'hABCD, 32'h20);
      tick();
      clr_disp();
      cdb_valid = 1'b0;
      sample();
      chk("bypass_iss_valid", 32'(iss_valid), 1);
      tick();
      sample();
      chk("bypass_occ_0", 32'(occupancy), 0);
      tick();

      // Simultaneous dispatch and issue at occupancy 2
      iss_ready = 1'b0;
      set_disp(AluOp_Add, 4'd10, 1'b1, 32'hA1, 4'd0, 1'b1, 32'hA2, 4'd0, 32'd0);
      tick();
      set_disp(AluOp_Sub, 4'd11, 1'b1, 32'hB1, 4'd0, 1'b1, 32'hB2, 4'd0, 32'd0);
      tick();
      set_disp(AluOp_And, 4'd12, 1'b1, 32'hC1, 4'd0, 1'b1, 32'hC2, 4'd0, 32'd0);
      iss_ready = 1'b1;
      push_exp(AluOp_Add, 4'd10, 32'hA1, 32'hA2, 32'd0);
      push_exp(AluOp_Sub, 4'd11, 32'hB1, 32'hB2, 32'd0);
      push_exp(AluOp_And, 4'd12, 32'hC1, 32'hC2, 32'd0);
      sample();
      chk("swap_occ_before", 32'(occupancy), 2);
      tick();
      clr_disp();
      sample();
      chk("swap_occ_after", 32'(occupancy), 2);
      chk("swap_older_survivor", 32'(iss_rob_tag), 11);
      tick();
      sample();
      chk("swap_then_young", 32'(iss_rob_tag), 12);
      tick();
      sample();
      chk("swap_occ_0", 32'(occupancy), 0);
      tick();

      // Flush with three entries and a concurrent dispatch
      iss_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_disp(AluOp_Or, 4'(13 + k), 1'b1, 32'(k), 4'd0, 1'b1, 32'(k), 4'd0, 32'd0);
         tick();
      end
      set_disp(AluOp_Xor, 4'd0, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 32'd0);
      flush = 1'b1;
      sample();
      chk("flush_occ_before", 32'(occupancy), 3);
      tick();
      flush = 1'b0;
      clr_disp();
      sample();
      chk("flush_occ", 32'(occupancy), 0);
      chk("flush_iss_valid", 32'(iss_valid), 0);
      chk("flush_disp_ready", 32'(disp_ready), 1);
      tick();

      // Asynchronous reset in mid-operation
      set_disp(AluOp_Add, 4'd1, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 4'd0, 32'h99);
      tick();
      set_disp(AluOp_Sub, 4'd2, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 32'd0);
      tick();
      clr_disp();
      sample();
      chk("prereset_occ", 32'(occupancy), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_occ", 32'(occupancy), 0);
      chk("async_reset_iss_valid", 32'(iss_valid), 0);
      chk("async_reset_iss_src1", iss_src1, 0);
      chk("async_reset_iss_imm", iss_imm, 0);
      chk("async_reset_disp_ready", 32'(disp_ready), 1);
      tick();
      rst_n = 1'b1;
      sample();
      chk("post_reset_occ", 32'(occupancy), 0);

      chk("expected_queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
